// File: rtl/snn_neuron_block.sv
// Time-stepped block of N leaky integrate-and-fire neurons. Consumes TS synaptic-count
// vectors, emits per-step spikes, and then holds each neuron's first-spike time for the packer.
module snn_neuron_block #(
   parameter int N      = 5,
   parameter int TS     = 20,
   parameter int TW     = $clog2(TS + 1),
   parameter int CW     = 4,
   parameter int VW     = 8,
   parameter int V_0    = 14,
   parameter int V_REST = 6,
   parameter int V_LEAK = 1,
   parameter int K_SYN  = 1,
   parameter int RP     = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*CW-1:0] in_syn,
   output logic            step_valid,
   output logic [N-1:0]    step_spikes,
   output logic [TW-1:0]   step_index,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*TW-1:0] spike_time,
   output logic            busy
);

   localparam int SW = VW + CW + 1;
   localparam int RW = $clog2(RP + 2);
   localparam logic [VW:0]   LEAK_FLOOR = (VW+1)'(V_REST + V_LEAK);
   localparam logic [VW-1:0] V_REST_W   = VW'(V_REST);
   localparam logic [VW-1:0] V_LEAK_W   = VW'(V_LEAK);
   localparam logic [VW-1:0] V_TH       = VW'(V_0);
   localparam logic [SW-1:0] V_MAX      = SW'((1 << VW) - 1);
   localparam logic [SW-1:0] GAIN       = SW'(K_SYN);
   localparam logic [RW-1:0] RP_W       = RW'(RP);
   localparam logic [TW-1:0] T_LAST     = TW'(TS - 1);
   localparam logic [TW-1:0] T_NONE     = TW'(TS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [VW-1:0]   v_q   [N];
   logic [RW-1:0]   r_q   [N];
   logic [N-1:0]    first_q;
   logic [TW-1:0]   t_q;

   logic [VW-1:0]   leak_v [N];
   logic [SW-1:0]   sum_v  [N];
   logic [VW-1:0]   sat_v  [N];
   logic [VW-1:0]   v_nxt  [N];
   logic [RW-1:0]   r_nxt  [N];
   logic [N-1:0]    fire;

   logic accept;
   assign accept = in_valid && in_ready;

   // Next membrane/refractory state for every neuron, as if the current beat were accepted.
   always_comb begin
      // NOTE: every variable gets a value on every path here, otherwise synthesis infers latches.
      fire = '0;
      for (int i = 0; i < N; i++) begin
         leak_v[i] = ({1'b0, v_q[i]} >= LEAK_FLOOR) ? v_q[i] - V_LEAK_W : V_REST_W;
         sum_v[i]  = SW'(leak_v[i]) + GAIN * SW'(in_syn[i*CW +: CW]);
         sat_v[i]  = (sum_v[i] > V_MAX) ? '1 : sum_v[i][VW-1:0];
         v_nxt[i]  = v_q[i];
         r_nxt[i]  = r_q[i];
         if (r_q[i] != '0) begin
            r_nxt[i] = r_q[i] - RW'(1);
            v_nxt[i] = V_REST_W;
         end else if (sat_v[i] >= V_TH) begin
            fire[i]  = 1'b1;
            v_nxt[i] = V_REST_W;
            r_nxt[i] = RP_W;
         end else begin
            v_nxt[i] = sat_v[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         in_ready    <= 1'b0;
         step_valid  <= 1'b0;
         step_spikes <= '0;
         step_index  <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         spike_time  <= {N{T_NONE}};
         first_q     <= '0;
         t_q         <= '0;
         // NOTE: neuron state is only N small registers, so it is reset explicitly rather than left undefined.
         for (int i = 0; i < N; i++) begin
            v_q[i] <= V_REST_W;
            r_q[i] <= '0;
         end
      end else begin
         step_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               for (int i = 0; i < N; i++) begin
                  v_q[i] <= V_REST_W;
                  r_q[i] <= '0;
               end
               spike_time <= {N{T_NONE}};
               first_q    <= '0;
               t_q        <= '0;
               in_ready   <= 1'b1;
               busy       <= 1'b1;
               state      <= RUN;
            end
            RUN: if (accept) begin
               for (int i = 0; i < N; i++) begin
                  v_q[i] <= v_nxt[i];
                  r_q[i] <= r_nxt[i];
                  if (fire[i] && !first_q[i]) begin
                     spike_time[i*TW +: TW] <= t_q;
                     first_q[i]             <= 1'b1;
                  end
               end
               step_valid  <= 1'b1;
               step_spikes <= fire;
               step_index  <= t_q;
               t_q         <= t_q + TW'(1);
               if (t_q == T_LAST) begin
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
